// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle control unit: state encodings, ALU codes,
// opcode classes, ALU command field values and datapath select encodings.
package mc_ctrl_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] FETCH  = 4'd0;
    localparam logic [STATE_W-1:0] DECODE = 4'd1;
    localparam logic [STATE_W-1:0] MEMADR = 4'd2;
    localparam logic [STATE_W-1:0] MEMRD  = 4'd3;
    localparam logic [STATE_W-1:0] MEMWB  = 4'd4;
    localparam logic [STATE_W-1:0] MEMWR  = 4'd5;
    localparam logic [STATE_W-1:0] EXECR  = 4'd6;
    localparam logic [STATE_W-1:0] EXECI  = 4'd7;
    localparam logic [STATE_W-1:0] ALUWB  = 4'd8;
    localparam logic [STATE_W-1:0] BRANCH = 4'd9;
    localparam logic [STATE_W-1:0] FAULT  = 4'd10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic is_wait_state(input logic [STATE_W-1:0] s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: maps cmd/S bits to ALUControl, FlagW and a
// register-write suppression flag. Outputs are zero when not active.
module mc_alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EXT_OPS   = 1'b1
) (
    input  logic [5:0]           Funct,
    input  logic                 active,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           FlagW,
    output logic                 NoWrite
);

    logic [2:0] code;
    logic       known;
    logic       arith;
    logic       cmp_like;
    logic       unused_funct;

    assign unused_funct = Funct[5];

    always_comb begin
        code     = ALU_ADD;
        known    = 1'b1;
        arith    = 1'b0;
        cmp_like = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin code = ALU_ADD; arith = 1'b1; end
            CMD_SUB: begin code = ALU_SUB; arith = 1'b1; end
            CMD_AND: code = ALU_AND;
            CMD_ORR: code = ALU_ORR;
            CMD_EOR: if (EXT_OPS) code = ALU_EOR; else known = 1'b0;
            CMD_MOV: if (EXT_OPS) code = ALU_MOV; else known = 1'b0;
            CMD_CMP: begin
                if (EXT_OPS) begin
                    code     = ALU_SUB;
                    arith    = 1'b1;
                    cmp_like = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
            CMD_TST: begin
                if (EXT_OPS) begin
                    code     = ALU_AND;
                    cmp_like = 1'b1;
                end else begin
                    known = 1'b0;
                end
            end
            default: known = 1'b0;
        endcase

        ALUControl = '0;
        FlagW      = 2'b00;
        NoWrite    = 1'b0;
        if (active) begin
            // Unknown commands fall back to ADD with no side effects at all
            ALUControl = ALUCTRL_W'(code);
            NoWrite    = cmp_like | ~known;
            if (known) FlagW = {Funct[0], Funct[0] & arith};
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control unit: main FSM with memory handshake, wait-state timeout
// and sticky fault, driving datapath selects and strobes.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter bit          EXT_OPS   = 1'b1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 MemReady,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 MemRd,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nowrite_q;
    logic               exec_active;
    logic               alu_nowrite;
    logic               timeout;
    logic               branch;

    assign exec_active = (state_q == EXECR) || (state_q == EXECI);
    assign timeout     = (TIMEOUT > 0) && !MemReady && (cnt_q == CNT_LAST);
    assign Fault       = (state_q == FAULT);

    mc_alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W),
        .EXT_OPS   (EXT_OPS)
    ) u_alu_decoder (
        .Funct      (Funct),
        .active     (exec_active && !reset),
        .ALUControl (ALUControl),
        .FlagW      (FlagW),
        .NoWrite    (alu_nowrite)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (MemReady) state_d = DECODE; else if (timeout) state_d = FAULT;
            DECODE: begin
                case (Op)
                    OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FAULT;
                endcase
            end
            EXECR, EXECI: state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            MEMADR: state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (MemReady) state_d = MEMWB; else if (timeout) state_d = FAULT;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (MemReady) state_d = FETCH; else if (timeout) state_d = FAULT;
            BRANCH: state_d = FETCH;
            FAULT:  state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    // Counting only while waiting in place; any exit or ready cycle clears it
    always_comb begin
        cnt_d = '0;
        if (is_wait_state(state_q) && !MemReady && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            nowrite_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (exec_active) nowrite_q <= alu_nowrite;
        end
    end

    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        MemRd     = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = 2'b00;
        RegSrc    = 2'b00;
        branch    = 1'b0;
        if (!reset) begin
            ImmSrc = Op;
            RegSrc = {Op == OP_MEM, Op == OP_BR};
            case (state_q)
                FETCH: begin
                    MemRd     = 1'b1;
                    IRWrite   = MemReady;
                    NextPC    = MemReady;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                DECODE: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                EXECI:  ALUSrcB = SRCB_IMM;
                ALUWB:  RegW = ~nowrite_q;
                MEMADR: ALUSrcB = SRCB_IMM;
                MEMRD: begin
                    AdrSrc = 1'b1;
                    MemRd  = 1'b1;
                end
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegW      = 1'b1;
                end
                MEMWR: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA   = SRCA_ALUOUT;
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    branch    = 1'b1;
                end
                default: ;
            endcase
        end
        PCS = ((Rd == 4'hF) & RegW) | branch;
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench: one EXT_OPS=1 unit (ALUCTRL_W=4) and one EXT_OPS=0 unit in
// lockstep on shared inputs, both with TIMEOUT=4.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       MemReady;

    logic [1:0] FlagW, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic       PCS, NextPC, RegW, MemW, MemRd, IRWrite, AdrSrc, Fault;
    logic [3:0] ALUControl;

    logic [1:0] FlagW_b, ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b, RegSrc_b;
    logic       PCS_b, NextPC_b, RegW_b, MemW_b, MemRd_b, IRWrite_b, AdrSrc_b, Fault_b;
    logic [2:0] ALUControl_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.ALUCTRL_W(4), .EXT_OPS(1'b1), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .MemRd(MemRd),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Fault(Fault)
    );

    mc_control_unit #(.ALUCTRL_W(3), .EXT_OPS(1'b0), .TIMEOUT(4)) u_dut_base (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .FlagW(FlagW_b), .PCS(PCS_b), .NextPC(NextPC_b), .RegW(RegW_b), .MemW(MemW_b),
        .MemRd(MemRd_b), .IRWrite(IRWrite_b), .AdrSrc(AdrSrc_b), .ResultSrc(ResultSrc_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .ImmSrc(ImmSrc_b), .RegSrc(RegSrc_b),
        .ALUControl(ALUControl_b), .Fault(Fault_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'b0; Rd = 4'd0; MemReady = 1'b0;
        cyc(); cyc();
        chk("rst_memrd", MemRd, 0);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_srca", ALUSrcA, 0);
        chk("rst_fault", Fault, 0);

        // ADD r3, S=1
        reset = 1'b0; Op = 2'b00; Funct = 6'b001001; Rd = 4'd3; MemReady = 1'b1;
        #1;
        chk("fetch_memrd", MemRd, 1);
        chk("fetch_irwrite", IRWrite, 1);
        chk("fetch_nextpc", NextPC, 1);
        chk("fetch_srca", ALUSrcA, 2'b01);
        chk("fetch_srcb", ALUSrcB, 2'b10);
        chk("fetch_res", ResultSrc, 2'b10);
        cyc();
        chk("dec_regw", RegW, 0);
        chk("dec_irwrite", IRWrite, 0);
        chk("dec_srca", ALUSrcA, 2'b01);
        cyc();
        chk("add_aluctl", ALUControl, 4'b0000);
        chk("add_flagw", FlagW, 2'b11);
        chk("add_srcb", ALUSrcB, 2'b00);
        cyc();
        chk("add_wb_regw", RegW, 1);
        chk("add_wb_pcs", PCS, 0);
        chk("add_wb_res", ResultSrc, 2'b00);
        chk("add_wb_flagw", FlagW, 2'b00);

        // CMP immediate, S=1
        cyc();
        chk("cmp_fetch_memrd", MemRd, 1);
        Funct = 6'b110101;
        cyc(); cyc();
        chk("cmp_aluctl", ALUControl, 4'b0001);
        chk("cmp_flagw", FlagW, 2'b11);
        chk("cmp_srcb", ALUSrcB, 2'b01);
        chk("cmp_base_flagw", FlagW_b, 2'b00);
        chk("cmp_base_aluctl", ALUControl_b, 3'b000);
        cyc();
        chk("cmp_wb_regw", RegW, 0);
        chk("cmp_base_wb_regw", RegW_b, 0);

        // LDR into r15 with three not-ready cycles
        cyc();
        Op = 2'b01; Funct = 6'b000001; Rd = 4'hF;
        cyc(); cyc();
        chk("ldr_adr_srca", ALUSrcA, 2'b00);
        chk("ldr_adr_srcb", ALUSrcB, 2'b01);
        chk("ldr_regsrc", RegSrc, 2'b10);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("ldr_wait_memrd", MemRd, 1);
            chk("ldr_wait_adrsrc", AdrSrc, 1);
        end
        cyc();
        MemReady = 1'b1;
        #1;
        chk("ldr_last_memrd", MemRd, 1);
        cyc();
        chk("ldr_wb_regw", RegW, 1);
        chk("ldr_wb_pcs", PCS, 1);
        chk("ldr_wb_res", ResultSrc, 2'b01);
        chk("ldr_wb_fault", Fault, 0);

        // STR with memory stuck not-ready -> timeout fault
        cyc();
        Funct = 6'b000000; Rd = 4'd2;
        cyc(); cyc();
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("str_wait_memw", MemW, 1);
        end
        cyc();
        chk("str_to_memw", MemW, 0);
        chk("str_to_fault", Fault, 1);
        chk("str_to_memrd", MemRd, 0);
        cyc();
        chk("str_to_fault_held", Fault, 1);
        reset = 1'b1;
        #1;
        chk("str_rst_memw", MemW, 0);
        cyc();
        chk("str_rst_fault", Fault, 0);
        chk("str_rst_memrd", MemRd, 0);

        // Undefined Op
        reset = 1'b0; MemReady = 1'b1; Op = 2'b11;
        #1;
        chk("und_fetch_memrd", MemRd, 1);
        cyc();
        chk("und_dec_regw", RegW, 0);
        chk("und_dec_memw", MemW, 0);
        cyc();
        chk("und_fault", Fault, 1);
        chk("und_regw", RegW, 0);
        chk("und_memw", MemW, 0);

        // Reset in the middle of a store
        reset = 1'b1;
        cyc();
        reset = 1'b0; Op = 2'b01; Funct = 6'b000000; MemReady = 1'b1;
        cyc(); cyc();
        MemReady = 1'b0;
        cyc();
        chk("mid_memw", MemW, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_memw", MemW, 0);
        chk("mid_rst_adrsrc", AdrSrc, 0);
        cyc();
        reset = 1'b0; MemReady = 1'b1;
        #1;
        chk("mid_fetch_memrd", MemRd, 1);
        chk("mid_fetch_fault", Fault, 0);

        // EOR r1 with S=1: extended on one unit, undefined on the other
        Op = 2'b00; Funct = 6'b000011; Rd = 4'd1;
        cyc(); cyc();
        chk("eor_aluctl", ALUControl, 4'b0100);
        chk("eor_flagw", FlagW, 2'b10);
        chk("eor_base_flagw", FlagW_b, 2'b00);
        cyc();
        chk("eor_wb_regw", RegW, 1);
        chk("eor_base_wb_regw", RegW_b, 0);

        // Branch
        cyc();
        Op = 2'b10;
        cyc(); cyc();
        chk("br_pcs", PCS, 1);
        chk("br_srca", ALUSrcA, 2'b10);
        chk("br_srcb", ALUSrcB, 2'b01);
        chk("br_regw", RegW, 0);
        cyc();
        chk("br_next_memrd", MemRd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Parametrised multicycle control unit for the ARM-subset processor.
- Successor to the fixed decoder plus main FSM pair.
- Adds variable-latency memory handshake (MemReady) and a memory timeout/fault state.
- Adds an extended ALU decoder (EOR, MOV, CMP, TST) with register-write suppression, and detection of undefined Op.
- Drives the multicycle datapath selects and strobes from Op/Funct/Rd of the latched instruction.

Parameters:
- ALUCTRL_W, 3: ALUControl width; must be >= 3; bits above [2] driven 0.
- EXT_OPS, 1: 1 enables EOR/MOV/CMP/TST decode; 0 decodes only ADD/SUB/AND/ORR.
- TIMEOUT, 16: max consecutive MemReady-low cycles in one wait state before FAULT; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]: I, cmd[3:0], S/L
- Rd  in  4  destination register
- MemReady  in  1  memory completes the current access this cycle
- FlagW  out  2  [1]=NZ write, [0]=CV write
- PCS  out  1  PC written by result
- NextPC  out  1  PC <= PC+4
- RegW  out  1  register file write
- MemW  out  1  memory write strobe
- MemRd  out  1  memory read request
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=ALU result
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=RD1, 01=PC, 10=ALUOut
- ALUSrcB  out  2  00=RD2, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [1]=(Op==01), [0]=(Op==10)
- ALUControl  out  ALUCTRL_W  ALU operation
- Fault  out  1  sticky; undefined Op or memory timeout

Behaviour:
- Reset: on the clock edge with reset=1, state<=FETCH, wait counter<=0, Fault<=0. While reset=1, every strobe (IRWrite, NextPC, RegW, MemW, MemRd, PCS, FlagW) is 0 and all selects are 0.
- Outputs are a function of state plus MemReady; no output registers.
- Reset asserted in any state, including mid-access, aborts the access; FETCH follows.
- FETCH: MemRd=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite=NextPC=MemReady. Go to DECODE on MemReady, otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10; next state by Op:
  - 00 with Funct[5]=0 -> EXECR
  - 00 with Funct[5]=1 -> EXECI
  - 01 -> MEMADR
  - 10 -> BRANCH
  - 11 -> FAULT
- EXECR: ALUSrcA=00, ALUSrcB=00, ALU decode active; -> ALUWB.
- EXECI: as EXECR but ALUSrcB=01; -> ALUWB.
- ALU decode, on Funct[4:1]:
  - 0100 ADD -> 000
  - 0010 SUB -> 001
  - 0000 AND -> 010
  - 1100 ORR -> 011
  - EXT_OPS=1 only: 0001 EOR -> 100; 1101 MOV -> 101; 1010 CMP -> 001 with NoWrite=1; 1000 TST -> 010 with NoWrite=1.
  - Any other code -> 000 with NoWrite=1 and FlagW=00.
  - FlagW[1]=Funct[0]; FlagW[0]=Funct[0] and (ADD|SUB|CMP). FlagW is nonzero only in EXECR/EXECI.
- ALUWB: ResultSrc=00, RegW=~NoWrite; NoWrite is registered at the end of EXEC. -> FETCH.
- MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 -> MEMRD, Funct[0]=0 -> MEMWR.
- MEMRD: AdrSrc=1, MemRd=1, ResultSrc=00; -> MEMWB on MemReady.
- MEMWB: ResultSrc=01, RegW=1; -> FETCH.
- MEMWR: AdrSrc=1, MemW=1, held until the MemReady cycle inclusive; -> FETCH on MemReady.
- BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1; -> FETCH.
- PCS = ((Rd==4'hF) & RegW) | Branch.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and on any MemReady=1 cycle.
  - Increments each MemReady=0 cycle in those states.
  - With TIMEOUT>0, when the count reaches TIMEOUT-1 and MemReady=0, next state is FAULT (TIMEOUT low cycles total).
  - Counter width is clog2(TIMEOUT+1).
- FAULT: all strobes 0, Fault=1; state held until reset.
- MemReady is ignored outside wait states.

Decomposition:
- Package mc_ctrl_pkg: state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT); ALU code constants; Op constants; select encodings.
- Sub-module mc_alu_decoder: combinational; inputs Funct, active; outputs ALUControl, FlagW, NoWrite; takes EXT_OPS and ALUCTRL_W.

Test Plan:
- ADD reg with S (Op=00, Funct=001001, Rd=3), MemReady=1 -> FETCH/DECODE/EXECR/ALUWB in 4 cycles; EXECR ALUControl=000, FlagW=11; ALUWB RegW=1, PCS=0.
- CMP imm (Op=00, Funct=110101), EXT_OPS=1 -> ALUControl=001, FlagW=11, RegW=0 in ALUWB. With EXT_OPS=0 -> FlagW=00, RegW=0.
- LDR (Op=01, Funct=000001, Rd=15), MemReady low 3 cycles in MEMRD -> MEMRD lasts 4 cycles; MEMWB RegW=1, PCS=1.
- STR with TIMEOUT=4, MemReady stuck 0 -> MemW high 4 cycles, then FAULT, Fault=1 and held; reset -> FETCH, Fault=0.
- Op=11 -> DECODE then FAULT with no RegW/MemW pulse.
- Reset asserted mid-MEMWR -> MemW=0 in the reset cycle; FETCH next, with MemRd=1.
